// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: loads with extension, sub-word stores via RMW.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning.
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] PARK_ADDR   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, RELEASE, MERGE, RESP
  } state_t;

  state_t        state;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_word;
  logic [1:0]    r_size;
  logic          r_sgn;
  logic          r_wr;
  logic          r_wph;
  logic [CW-1:0] cnt;

  logic          mis;
  logic          oor;
  logic          bad;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld_val;
  logic [31:0]   mrg;

  assign req_ready = (state == IDLE);
  assign stall = (state != IDLE && state != RESP) ||
                 (state == IDLE && req_valid);

  always_comb begin
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    oor = {2'b00, req_addr[31:2]} >= 32'(DEPTH);
    bad = (req_read && req_write) || req_size == 2'b11 || oor || mis;
  end

  always_comb begin
    lb = r_word[{r_addr[1:0], 3'b000} +: 8];
    lh = r_word[{r_addr[1], 4'b0000} +: 16];
    ld_val = r_word;
    unique case (r_size)
      2'b00:   ld_val = {{24{r_sgn & lb[7]}}, lb};
      2'b01:   ld_val = {{16{r_sgn & lh[15]}}, lh};
      default: ld_val = r_word;
    endcase
    mrg = r_word;
    if (r_size == 2'b00)
      mrg[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      mrg[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= PARK_ADDR;
      mem_write_data <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_word         <= '0;
      r_size         <= '0;
      r_sgn          <= 1'b0;
      r_wr           <= 1'b0;
      r_wph          <= 1'b0;
      cnt            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_sgn   <= req_signed;
            r_wr    <= req_write;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_read && !req_write) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              // sub-word stores start with a read phase
              state          <= SETUP;
              r_wph          <= req_write && req_size == 2'b10;
              mem_read       <= !(req_write && req_size == 2'b10);
              mem_write      <= req_write && req_size == 2'b10;
              mem_write_data <= (req_write && req_size == 2'b10) ?
                                req_wdata : 32'd0;
              mem_addr       <= PARK_ADDR;
            end
          end
        end
        SETUP: begin
          state    <= ACCESS;
          mem_addr <= {2'b00, r_addr[31:2]};
          cnt      <= '0;
        end
        ACCESS: begin
          if (cnt == CW'(WAIT_CYCLES - 1)) begin
            r_word    <= mem_read_data;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          mem_addr <= PARK_ADDR;
          if (r_wr && !r_wph) begin
            state <= MERGE;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= r_wr ? 32'd0 : ld_val;
          end
        end
        MERGE: begin
          mem_write_data <= mrg;
          mem_write      <= 1'b1;
          r_wph          <= 1'b1;
          state          <= SETUP;
        end
        RESP: begin
          state          <= IDLE;
          resp_valid     <= 1'b0;
          resp_rdata     <= '0;
          resp_err       <= 1'b0;
          mem_write_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl against a word-addressed memory model.
// Expected results come from a reference memory plus literal values.
module tb_mem_access_ctrl;

  localparam int          W       = 2;
  localparam int          DEP     = 256;
  localparam logic [31:0] PARK    = 32'hFFFF_FFFF;
  localparam int          LAT_W   = W + 3;
  localparam int          LAT_RMW = 2 * (W + 2) + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  mem_access_ctrl #(
    .WAIT_CYCLES(W),
    .DEPTH(DEP),
    .PARK_ADDR(PARK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_read(req_read),
    .req_write(req_write),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .stall(stall),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [DEP];
  logic [31:0] ref_m [DEP];

  initial begin
    for (int i = 0; i < DEP; i++) begin
      dmem[i]  = 32'(i);
      ref_m[i] = 32'(i);
    end
  end

  assign mem_read_data = (mem_addr < 32'(DEP)) ? dmem[mem_addr[7:0]] : 32'd0;

  always @(posedge clk)
    if (mem_write && mem_addr < 32'(DEP))
      dmem[mem_addr[7:0]] <= mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sbq[$];

  // protocol monitors
  int excl_viol = 0;
  int jump_viol = 0;
  logic [31:0] prev_addr = PARK;
  always @(negedge clk) begin
    if (mem_read && mem_write) excl_viol++;
    if (prev_addr != PARK && mem_addr != PARK && mem_addr != prev_addr)
      jump_viol++;
    prev_addr = mem_addr;
  end

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sbq.size() == 0) begin
        check("unexp_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rdata", resp_rdata, e.rdata);
        check("err", {31'd0, resp_err}, {31'd0, e.err});
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
        check("stall_resp", {31'd0, stall}, 32'd0);
      end
    end
  end

  task automatic model(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input bit commit,
                       output exp_t e);
    logic [29:0] idx;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    bit          mis;
    idx = ad[31:2];
    mis = 0;
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
`endif
    e.err   = (rd && wr) || sz == 2'd3 || idx >= 30'(DEP) || mis;
    e.rdata = '0;
    e.lat   = 1;
    e.t0    = 0;
    if (!e.err && (rd || wr)) begin
      w = ref_m[idx[7:0]];
      if (rd) begin
        e.lat = LAT_W;
        case (ad[1:0])
          2'd0: b = w[7:0];
          2'd1: b = w[15:8];
          2'd2: b = w[23:16];
          default: b = w[31:24];
        endcase
        h = ad[1] ? w[31:16] : w[15:0];
        case (sz)
          2'd0: e.rdata = sg ? {{24{b[7]}}, b} : {24'd0, b};
          2'd1: e.rdata = sg ? {{16{h[15]}}, h} : {16'd0, h};
          default: e.rdata = w;
        endcase
      end else begin
        if (sz == 2'd2) begin
          w = wd;
          e.lat = LAT_W;
        end else begin
          e.lat = LAT_RMW;
          if (sz == 2'd0) begin
            case (ad[1:0])
              2'd0: w[7:0]   = wd[7:0];
              2'd1: w[15:8]  = wd[7:0];
              2'd2: w[23:16] = wd[7:0];
              default: w[31:24] = wd[7:0];
            endcase
          end else if (ad[1]) begin
            w[31:16] = wd[15:0];
          end else begin
            w[15:0] = wd[15:0];
          end
        end
        if (commit) ref_m[idx[7:0]] = w;
      end
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input bit use_lit,
                       input logic [31:0] lit, input bit abort);
    exp_t e;
    bit   acc;
    @(negedge clk);
    req_read   = rd;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    req_valid  = 1'b1;
    #1;
    acc = 0;
    for (int n = 0; n < 60 && !acc; n++) begin
      if (req_ready) acc = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    check("stall_req", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    model(rd, wr, sz, sg, ad, wd, !abort, e);
    if (use_lit) e.rdata = lit;
    e.t0 = cyc - 1;
    if (!abort) sbq.push_back(e);
    req_valid  = 1'b0;
    req_read   = 1'($urandom);
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_addr", mem_addr, PARK);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // lw 0x20 with pin timing
    issue(1, 0, 2'd2, 0, 32'h20, 0, 1, 32'h8, 0);
    @(negedge clk);
    check("lw_setup_rd", {31'd0, mem_read}, 32'd1);
    check("lw_setup_addr", mem_addr, PARK);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("lw_acc_rd", {31'd0, mem_read}, 32'd1);
      check("lw_acc_addr", mem_addr, 32'd8);
    end
    @(negedge clk);
    check("lw_rel_rd", {31'd0, mem_read}, 32'd0);
    check("lw_rel_addr", mem_addr, 32'd8);
    @(negedge clk);
    check("lw_resp_addr", mem_addr, PARK);
    drain();

    issue(0, 1, 2'd2, 0, 32'h24, 32'hDEADBEEF, 0, 0, 0);
    issue(1, 0, 2'd2, 0, 32'h24, 0, 1, 32'hDEADBEEF, 0);

    issue(0, 1, 2'd0, 0, 32'h29, 32'h80, 0, 0, 0);
    issue(1, 0, 2'd0, 1, 32'h29, 0, 1, 32'hFFFFFF80, 0);
    issue(1, 0, 2'd0, 0, 32'h29, 0, 1, 32'h00000080, 0);
    drain();
    check("sb_word", dmem[10], 32'h0000800A);

    issue(0, 1, 2'd2, 0, 32'h2C, 32'h80010000, 0, 0, 0);
    issue(1, 0, 2'd1, 1, 32'h2E, 0, 1, 32'hFFFF8001, 0);
    issue(1, 0, 2'd1, 0, 32'h2C, 0, 1, 32'h00000000, 0);
    drain();

    issue(1, 0, 2'd2, 0, 32'h400, 0, 0, 0, 0);
    @(negedge clk);
    check("oor_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    check("oor_addr", mem_addr, PARK);
    issue(1, 1, 2'd2, 0, 32'h10, 0, 0, 0, 0);
    @(negedge clk);
    check("rw_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    issue(1, 0, 2'd3, 0, 32'h10, 0, 0, 0, 0);
    issue(0, 0, 2'd2, 0, 32'h10, 0, 0, 0, 0);
    issue(1, 0, 2'd2, 0, 32'h22, 0, 0, 0, 0);
    issue(1, 0, 2'd1, 1, 32'h23, 0, 0, 0, 0);
    drain();

    for (int k = 0; k < 24; k++) begin
      int op;
      logic [31:0] ad;
      op = $urandom_range(0, 11);
      ad = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) ad = 32'h0000_0800;
      issue(op < 5, op >= 5 && op < 10 || op == 10, 2'($urandom_range(0, 3)),
            1'($urandom), ad, $urandom, 0, 0, 0);
    end
    drain();

    // reset during the write-phase setup of an RMW store
    issue(0, 1, 2'd0, 0, 32'h30, 32'h55, 0, 0, 1);
    seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (mem_write) seen = 1;
    end
    check("wph_seen", {31'd0, seen}, 32'd1);
    check("wph_setup_addr", mem_addr, PARK);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_ready", {31'd0, req_ready}, 32'd1);
    check("mrst_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    check("mrst_addr", mem_addr, PARK);
    check("mrst_wdata", mem_write_data, 32'd0);
    check("mrst_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_mem", dmem[12], 32'h0000000C);
    issue(1, 0, 2'd2, 0, 32'h30, 0, 1, 32'h0000000C, 0);
    drain();

    check("excl", 32'(excl_viol), 32'd0);
    check("park_jump", 32'(jump_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
